// File: rtl/tsm_toy_sequencer_pkg.sv
// Shared definitions for the toy sequencer: LFSR constants, FSM state
// encoding and the unrolled 20-step LFSR advance.
package tsm_pkg;

  // Galois mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  function automatic logic [31:0] lfsr_step20(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < 20; i++) begin
      r = r[0] ? ((r >> 1) ^ LFSR_POLY) : (r >> 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/tsm_toy_sequencer_if.sv
// Operand and result streams of the toy sequencer.
//   in_valid/in_ready/in_share1/in_share2     : 2-share operand stream
//   out_valid/out_ready/out_share1/out_share2 : 2-share result stream
// slave  = sequencer side, master = producer/consumer side.
interface tsm_toy_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_share1;
  logic [3:0] in_share2;
  logic       out_valid;
  logic       out_ready;
  logic       out_share1;
  logic       out_share2;

  modport slave (
    input  in_valid, in_share1, in_share2, out_ready,
    output in_ready, out_valid, out_share1, out_share2
  );

  modport master (
    output in_valid, in_share1, in_share2, out_ready,
    input  in_ready, out_valid, out_share1, out_share2
  );
endinterface

// File: rtl/tsm_toy_sequencer_share_fifo.sv
// tsm_share_fifo: DEPTH x 2-bit synchronous FIFO holding result share pairs.
//   push_i/din_i : write side
//   pop_i/dout_o : read side, dout_o is 0 while empty
//   empty_o      : no entries
//   count_o      : occupancy 0..DEPTH
module tsm_share_fifo #(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [1:0]    din_i,
  input  logic          pop_i,
  output logic [1:0]    dout_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          full, wr_en, rd_en;

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  // a push into a full FIFO is only taken when a pop frees a slot the same cycle
  assign wr_en   = push_i && (!full || pop_i);
  assign rd_en   = pop_i && !empty_o;
  assign dout_o  = empty_o ? 2'b00 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (rd_en) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/tsm_toy_sequencer.sv
// tsm_toy_sequencer: feeds 2-share operands into the non-stalling masked
// toy datapath, supplies 20 fresh random bits per cycle and buffers results.
//   clk, rst              : clock, async active-high reset
//   seed_load, seed       : reload LFSR (0 -> 1) and restart warm-up
//   flush                 : stop accepting until pipeline and FIFO are empty
//   bus (slave)           : operand and result streams
//   dp_share1/2, dp_rand  : datapath inputs
//   dp_out_share1/2       : datapath result
//   busy                  : results in flight or buffered
//
// state     | meaning
// ST_WARMUP | LFSR mixing after reset/seed load, no accepts
// ST_RUN    | accepting operands while credits remain
// ST_DRAIN  | flush requested, waiting for pipeline and FIFO to empty
module tsm_toy_sequencer
  import tsm_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4,
  parameter int WARMUP  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [31:0]       seed,
  input  logic              flush,
  tsm_toy_sequencer_if.slave bus,
  output logic [3:0]        dp_share1,
  output logic [3:0]        dp_share2,
  output logic [19:0]       dp_rand,
  input  logic              dp_out_share1,
  input  logic              dp_out_share2,
  output logic              busy
);

  localparam int CNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [19:0]        rand_q;
  logic [LATENCY:0]   vld_q;
  logic [3:0]         dps1_q, dps2_q;
  logic               in_ready_c, accept, credit_ok, pop;
  logic [7:0]         inflight;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_cnt;
  logic [1:0]         fifo_dout;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_WARMUP;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WARMUP: if (wcnt_q == CNT_W'(WARMUP - 1)) state_d = ST_RUN;
      ST_RUN:    if (flush) state_d = ST_DRAIN;
      ST_DRAIN:  if ((vld_q == '0) && fifo_empty) state_d = ST_RUN;
      default:   state_d = ST_WARMUP;
    endcase
    if (seed_load) state_d = ST_WARMUP;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready_c = 1'b0;
    wcnt_d     = '0;
    if ((state_q == ST_RUN) && credit_ok) in_ready_c = 1'b1;
    if ((state_q == ST_WARMUP) && !seed_load) wcnt_d = wcnt_q + CNT_W'(1);
  end

  // Credits: everything already committed (in flight + buffered) must fit in
  // the FIFO, since the datapath cannot be stalled.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= LATENCY; i++) inflight = inflight + 8'(vld_q[i]);
  end
  assign credit_ok = (8'(fifo_cnt) + inflight) < 8'(DEPTH);

  assign accept       = bus.in_valid && in_ready_c;
  assign bus.in_ready = in_ready_c;

  assign lfsr_d = seed_load ? ((seed == 32'h0) ? LFSR_SEED : seed)
                            : lfsr_step20(lfsr_q);

  // ---------------- LFSR, datapath drive, valid pipeline ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
      rand_q <= '0;
      vld_q  <= '0;
      dps1_q <= '0;
      dps2_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      rand_q <= lfsr_d[19:0];
      vld_q  <= {vld_q[LATENCY-1:0], accept};
      // idle cycles drive zeros so no secret share lingers on the datapath
      dps1_q <= accept ? bus.in_share1 : 4'h0;
      dps2_q <= accept ? bus.in_share2 : 4'h0;
    end
  end

  assign dp_share1 = dps1_q;
  assign dp_share2 = dps2_q;
  assign dp_rand   = rand_q;

  // ---------------- result buffer ----------------
  assign pop = bus.out_valid && bus.out_ready;

  tsm_share_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (vld_q[LATENCY]),
    .din_i   ({dp_out_share1, dp_out_share2}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign bus.out_valid  = !fifo_empty;
  assign bus.out_share1 = fifo_dout[1];
  assign bus.out_share2 = fifo_dout[0];
  assign busy           = (vld_q != '0) || !fifo_empty;

endmodule
